// File: rtl/nchan_scan_mux.sv
// N-channel registered mux with a valid/ready output register.
// Manual mode loads a selected channel; scan mode round-robins enabled channels with a dwell gap.
module nchan_scan_mux #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] din,
  input  logic [N_CH-1:0]        ch_en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic                   start,
  output logic [DATA_W-1:0]      dout,
  output logic [SEL_W-1:0]       dout_ch,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_ACK, DWELL} state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    ptr, ptr_nxt;
  logic [DWELL_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0]   dout_nxt;
  logic [SEL_W-1:0]    dout_ch_nxt;
  logic                valid_nxt;

  logic [DATA_W-1:0]   man_data, ptr_data;
  logic [SEL_W-1:0]    first_ptr, adv_ptr;
  logic                above_found, any_en;

  // Channel lookups compare the index against every real channel, so an
  // out-of-range sel simply matches nothing and yields zero data.
  always_comb begin
    man_data    = '0;
    ptr_data    = '0;
    first_ptr   = '0;
    adv_ptr     = '0;
    above_found = 1'b0;
    any_en      = |ch_en;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) man_data = din[k*DATA_W +: DATA_W];
      if (ptr == SEL_W'(k)) ptr_data = din[k*DATA_W +: DATA_W];
    end
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_en[k]) first_ptr = SEL_W'(k);
      if (ch_en[k] && (k > int'(ptr))) begin
        adv_ptr     = SEL_W'(k);
        above_found = 1'b1;
      end
    end
    if (!above_found) adv_ptr = first_ptr;
  end

  // Handshake: a transfer happens on any rising edge where dout_valid and
  // dout_ready are both high; dout/dout_ch never change while valid waits.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    dout_nxt    = dout;
    dout_ch_nxt = dout_ch;
    valid_nxt   = dout_valid;
    case (state)
      IDLE: begin
        if (!mode) begin
          if (!dout_valid || dout_ready) begin
            dout_nxt    = man_data;
            dout_ch_nxt = sel;
            valid_nxt   = 1'b1;
          end
        end else begin
          if (dout_valid && dout_ready) valid_nxt = 1'b0;
          if (start && any_en) begin
            ptr_nxt   = first_ptr;
            state_nxt = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (!mode) begin
          state_nxt = IDLE;
        end else begin
          dout_nxt    = ptr_data;
          dout_ch_nxt = ptr;
          valid_nxt   = 1'b1;
          state_nxt   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (dout_ready) begin
          valid_nxt = 1'b0;
          cnt_nxt   = dwell;
          if (!mode) begin
            state_nxt = IDLE;
          end else if (dwell == '0) begin
            ptr_nxt   = adv_ptr;
            state_nxt = any_en ? CAPTURE : IDLE;
          end else begin
            state_nxt = DWELL;
          end
        end
      end
      DWELL: begin
        if (!mode) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
          // cnt was loaded with dwell, so the last dwell cycle sees cnt==1
          if (cnt <= DWELL_W'(1)) begin
            ptr_nxt   = adv_ptr;
            state_nxt = any_en ? CAPTURE : IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      dout_ch    <= dout_ch_nxt;
      dout_valid <= valid_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_nchan_scan_mux.sv
// Bench for nchan_scan_mux: manual loads, scan order/timing, backpressure, aborts, reset.
// Scan expectations come from the channel-order and dwell-timing rules, not the FSM.
module tb_nchan_scan_mux;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DW = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  din;
  logic [N-1:0]    ch_en;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [DW-1:0]   dwell;
  logic            start;
  logic [W-1:0]    dout;
  logic [SW-1:0]   dout_ch;
  logic            dout_valid;
  logic            dout_ready;
  logic            busy;

  logic [6*W-1:0]  din6;
  logic [5:0]      ch_en6;
  logic            mode6;
  logic [2:0]      sel6;
  logic [DW-1:0]   dwell6;
  logic            start6;
  logic [W-1:0]    dout6;
  logic [2:0]      dout_ch6;
  logic            dout_valid6;
  logic            dout_ready6;
  logic            busy6;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int seen_ch[$];

  always #5 clk = ~clk;

  nchan_scan_mux #(.N_CH(N), .DATA_W(W), .DWELL_W(DW)) u_dut (
    .clk(clk), .rst(rst), .din(din), .ch_en(ch_en), .mode(mode), .sel(sel),
    .dwell(dwell), .start(start), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  nchan_scan_mux #(.N_CH(6), .DATA_W(W), .DWELL_W(DW)) u_dut6 (
    .clk(clk), .rst(rst), .din(din6), .ch_en(ch_en6), .mode(mode6), .sel(sel6),
    .dwell(dwell6), .start(start6), .dout(dout6), .dout_ch(dout_ch6),
    .dout_valid(dout_valid6), .dout_ready(dout_ready6), .busy(busy6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next enabled channel strictly after p, wrapping; -1 if none enabled.
  function automatic int ref_next(int p, logic [N-1:0] en);
    int c;
    for (int i = 1; i <= N; i++) begin
      c = (p + i) % N;
      if (en[c]) return c;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 2'd1; din = $urandom; dout_ready = 1'b1;
    step();
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %0h expected 0", dout); end
    checks++; if (dout_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", dout_ch); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dout_valid6 !== 1'b0) begin errors++; $display("FAIL reset_valid6: got %b expected 0", dout_valid6); end
    rst = 1'b0;
  endtask

  task automatic test_manual_directed();
    mode = 1'b0; dout_ready = 1'b1; sel = 2'd2;
    din = $urandom; din[2*W +: W] = 8'hA5;
    step();
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL man_dout_a5: got %0h expected a5", dout); end
    checks++; if (dout_ch !== 2'd2) begin errors++; $display("FAIL man_ch2: got %0d expected 2", dout_ch); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL man_valid: got %b expected 1", dout_valid); end
    sel = 2'd3; din[3*W +: W] = 8'h3C;
    step();
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL man_dout_3c: got %0h expected 3c", dout); end
    checks++; if (dout_ch !== 2'd3) begin errors++; $display("FAIL man_ch3: got %0d expected 3", dout_ch); end
  endtask

  // Reference: a single output register that loads whenever it is empty or being drained.
  task automatic test_manual_random();
    logic [W-1:0]  exp_d;
    logic [SW-1:0] exp_c;
    logic          exp_v;
    rst = 1'b1; step(); rst = 1'b0;
    exp_d = '0; exp_c = '0; exp_v = 1'b0;
    mode = 1'b0;
    for (int i = 0; i < 60; i++) begin
      din = $urandom;
      sel = SW'($urandom_range(0, N - 1));
      dout_ready = ($urandom_range(0, 2) != 0);
      if (!exp_v || dout_ready) begin
        exp_d = din[int'(sel)*W +: W];
        exp_c = sel;
        exp_v = 1'b1;
      end
      step();
      checks++; if (dout !== exp_d) begin errors++; $display("FAIL man_rand_dout[%0d]: got %0h expected %0h", i, dout, exp_d); end
      checks++; if (dout_ch !== exp_c) begin errors++; $display("FAIL man_rand_ch[%0d]: got %0d expected %0d", i, dout_ch, exp_c); end
      checks++; if (dout_valid !== exp_v) begin errors++; $display("FAIL man_rand_valid[%0d]: got %b expected %b", i, dout_valid, exp_v); end
    end
  endtask

  // Scan scenario engine. rmode: 0 ready high, 1 random ready, 2 first sample stalled 5 cycles.
  // Rules: first sample one edge after start; each next sample dwell+1 edges after its
  // predecessor's transfer; channels follow ref_next order; stalled outputs hold.
  task automatic scan_run(input logic [N-1:0] en, input int dw, input int rmode,
                          input int ncyc, input bit do_rst);
    int exp_ch, need, since, stall_left;
    logic v0, rdy;
    logic [W-1:0] d0;
    logic [SW-1:0] c0;
    logic [N*W-1:0] pre_din;
    seen_ch.delete();
    exp_q.delete();
    if (do_rst) begin
      rst = 1'b1; start = 1'b0; step(); rst = 1'b0;
    end
    mode = 1'b1; ch_en = en; dwell = DW'(dw); dout_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL scan_start_busy: got %b expected 1", busy); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL scan_start_valid: got %b expected 0", dout_valid); end
    exp_ch = ref_next(N - 1, en);
    need = 1; since = 0; stall_left = 5;
    for (int i = 0; i < ncyc; i++) begin
      v0 = dout_valid; d0 = dout; c0 = dout_ch;
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        default: begin
          rdy = !(v0 && stall_left > 0);
          if (v0 && stall_left > 0) stall_left--;
        end
      endcase
      dout_ready = rdy;
      din = $urandom;
      pre_din = din;
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL scan_busy[%0d]: got %b expected 1", i, busy); end
      if (v0) begin
        if (!rdy) begin
          checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, dout_valid); end
          checks++; if (dout !== d0) begin errors++; $display("FAIL stall_dout[%0d]: got %0h expected %0h", i, dout, d0); end
          checks++; if (dout_ch !== c0) begin errors++; $display("FAIL stall_ch[%0d]: got %0d expected %0d", i, dout_ch, c0); end
        end else begin
          checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL post_xfer_valid[%0d]: got %b expected 0", i, dout_valid); end
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL xfer_unexpected[%0d]: got data %0h expected no sample", i, d0);
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (d0 !== e) begin errors++; $display("FAIL xfer_data[%0d]: got %0h expected %0h", i, d0, e); end
          end
          since = 0;
          need = dw + 1;
        end
      end else begin
        since++;
        checks++; if (dout_valid !== (since == need)) begin errors++; $display("FAIL scan_valid_timing[%0d]: got %b expected %b", i, dout_valid, since == need); end
        if (since == need) begin
          checks++; if (int'(dout_ch) !== exp_ch) begin errors++; $display("FAIL scan_ch[%0d]: got %0d expected %0d", i, dout_ch, exp_ch); end
          checks++; if (dout !== pre_din[exp_ch*W +: W]) begin errors++; $display("FAIL scan_dout[%0d]: got %0h expected %0h", i, dout, pre_din[exp_ch*W +: W]); end
          exp_q.push_back(pre_din[exp_ch*W +: W]);
          seen_ch.push_back(exp_ch);
          exp_ch = ref_next(exp_ch, en);
        end
      end
    end
  endtask

  task automatic test_scan_order();
    int exp_seq [5];
    exp_seq = '{0, 1, 3, 0, 1};
    scan_run(4'b1011, 2, 0, 24, 1'b1);
    checks++; if (seen_ch.size() !== 6) begin errors++; $display("FAIL scan_order_count: got %0d expected 6", seen_ch.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < seen_ch.size()) begin
        checks++; if (seen_ch[i] !== exp_seq[i]) begin errors++; $display("FAIL scan_order[%0d]: got %0d expected %0d", i, seen_ch[i], exp_seq[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    scan_run(4'b0011, 3, 2, 30, 1'b1);
  endtask

  task automatic test_scan_random();
    for (int r = 0; r < 4; r++)
      scan_run(N'($urandom_range(1, 15)), $urandom_range(0, 4), 1, 60, 1'b1);
  endtask

  task automatic test_edge_no_enable();
    rst = 1'b1; step(); rst = 1'b0;
    mode = 1'b1; ch_en = '0; dout_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noen_busy[%0d]: got %b expected 0", i, busy); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL noen_valid[%0d]: got %b expected 0", i, dout_valid); end
      step();
    end
  endtask

  task automatic test_edge_single();
    scan_run(4'b0100, 0, 0, 12, 1'b1);
    checks++; if (seen_ch.size() !== 6) begin errors++; $display("FAIL single_count: got %0d expected 6", seen_ch.size()); end
  endtask

  task automatic test_manual_n6();
    logic [2:0] s;
    for (int k = 5; k <= 7; k++) begin
      s = 3'(k);
      sel6 = s;
      din6 = {$urandom, 16'($urandom)};
      din6[5*W +: W] = 8'h5A;
      step();
      checks++; if (dout_ch6 !== s) begin errors++; $display("FAIL n6_ch[%0d]: got %0d expected %0d", k, dout_ch6, s); end
      checks++; if (dout6 !== ((k == 5) ? 8'h5A : 8'h00)) begin errors++; $display("FAIL n6_dout[%0d]: got %0h expected %0h", k, dout6, (k == 5) ? 8'h5A : 8'h00); end
      checks++; if (dout_valid6 !== 1'b1) begin errors++; $display("FAIL n6_valid[%0d]: got %b expected 1", k, dout_valid6); end
    end
  endtask

  task automatic test_abort_dwell();
    rst = 1'b1; step(); rst = 1'b0;
    mode = 1'b1; ch_en = 4'b0001; dwell = 8'd4; dout_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_dwell_pre_busy: got %b expected 1", busy); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL abort_dwell_pre_valid: got %b expected 0", dout_valid); end
    mode = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_dwell_busy: got %b expected 0", busy); end
  endtask

  task automatic test_abort_wait();
    logic [W-1:0] exp_d;
    rst = 1'b1; step(); rst = 1'b0;
    mode = 1'b1; ch_en = 4'b0110; dwell = 8'd1; dout_ready = 1'b0; start = 1'b1;
    din = $urandom;
    exp_d = din[1*W +: W];
    step();
    start = 1'b0;
    step();
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL abort_wait_valid0: got %b expected 1", dout_valid); end
    checks++; if (dout_ch !== 2'd1) begin errors++; $display("FAIL abort_wait_ch: got %0d expected 1", dout_ch); end
    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = $urandom;
      step();
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL abort_wait_hold_valid[%0d]: got %b expected 1", i, dout_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_wait_hold_busy[%0d]: got %b expected 1", i, busy); end
      checks++; if (dout !== exp_d) begin errors++; $display("FAIL abort_wait_hold_dout[%0d]: got %0h expected %0h", i, dout, exp_d); end
    end
    dout_ready = 1'b1;
    step();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL abort_wait_valid: got %b expected 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_wait_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    mode = 1'b1; ch_en = 4'b1011; dwell = 8'd2; dout_ready = 1'b1; start = 1'b1;
    din = $urandom;
    step();
    start = 1'b0;
    step();
    step();
    dout_ready = 1'b0;
    step();
    step();
    step();
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", dout_valid); end
    checks++; if (dout_ch !== 2'd1) begin errors++; $display("FAIL rstmid_pre_ch: got %0d expected 1", dout_ch); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", dout_valid); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %0h expected 0", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_busy: got %b expected 0", busy); end
    scan_run(4'b1011, 2, 0, 10, 1'b0);
    checks++; if (seen_ch.size() == 0 || seen_ch[0] !== 0) begin errors++; $display("FAIL rstmid_rescan_first: got %0d expected 0", (seen_ch.size() == 0) ? -1 : seen_ch[0]); end
  endtask

  initial begin
    rst = 1'b1; din = '0; ch_en = '0; mode = 1'b0; sel = '0; dwell = '0;
    start = 1'b0; dout_ready = 1'b1;
    din6 = '0; ch_en6 = '0; mode6 = 1'b0; sel6 = '0; dwell6 = '0;
    start6 = 1'b0; dout_ready6 = 1'b1;
    test_reset();
    test_manual_directed();
    test_manual_random();
    test_scan_order();
    test_backpressure();
    test_scan_random();
    test_edge_no_enable();
    test_edge_single();
    test_manual_n6();
    test_abort_dwell();
    test_abort_wait();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
